// File: rtl/puf_eval_ctrl_if.sv
// Request/response handshake plus PUF array wiring for puf_eval_ctrl.
// The master modport is the controller's view; slave is the surrounding system.
interface puf_eval_ctrl_if #(
    parameter int N_PUF = 6,
    parameter int SEL_W = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_sel;
    logic [SEL_W-1:0] puf_sel;
    logic             puf_ce;
    logic [N_PUF-1:0] puf_q;
    logic [N_PUF-1:0] puf_qn;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N_PUF-1:0] rsp_bits;
    logic [N_PUF-1:0] rsp_unstable;
    logic [N_PUF-1:0] rsp_invalid;

    modport master (
        input  req_valid, req_sel, puf_q, puf_qn, rsp_ready,
        output req_ready, puf_sel, puf_ce, rsp_valid, rsp_bits, rsp_unstable, rsp_invalid
    );

    modport slave (
        output req_valid, req_sel, puf_q, puf_qn, rsp_ready,
        input  req_ready, puf_sel, puf_ce, rsp_valid, rsp_bits, rsp_unstable, rsp_invalid
    );
endinterface

// File: rtl/puf_eval_ctrl.sv
// PUF evaluation sequencer: precharge/evaluate/sample NEVAL times per challenge,
// majority-vote each bit and report instability and Q==Qn faults.
module puf_eval_ctrl #(
    parameter int N_PUF   = 6,
    parameter int SEL_W   = 32,
    parameter int NEVAL   = 5,
    parameter int PRE_CYC = 4,
    parameter int SETTLE  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    puf_eval_ctrl_if.master bus
);
    localparam int CNT_W   = $clog2(NEVAL + 1);
    localparam int EVC_W   = (NEVAL > 1) ? $clog2(NEVAL) : 1;
    localparam int CYC_MAX = (PRE_CYC > SETTLE) ? PRE_CYC : SETTLE;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    typedef enum logic [2:0] {IDLE, PRE, EVAL, SAMPLE, DONE} state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic                          w_accept;
    logic [N_PUF-1:0]              r_q_s1, r_q_s2, r_qn_s1, r_qn_s2;
    logic [CYC_W-1:0]              r_cyc_cnt;
    logic [EVC_W-1:0]              r_eval_cnt;
    logic [N_PUF-1:0][CNT_W-1:0]   r_ones_cnt;
    logic [N_PUF-1:0][CNT_W-1:0]   w_final_cnt;
    logic [N_PUF-1:0]              r_invalid, w_final_inv;
    logic [N_PUF-1:0]              w_maj, w_unst;
    logic [SEL_W-1:0]              r_sel;
    logic                          r_ce;
    logic                          r_rsp_valid;
    logic [N_PUF-1:0]              r_rsp_bits, r_rsp_unstable, r_rsp_invalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_s1  <= '0;
            r_q_s2  <= '0;
            r_qn_s1 <= '0;
            r_qn_s2 <= '0;
        end else begin
            r_q_s1  <= bus.puf_q;
            r_q_s2  <= r_q_s1;
            r_qn_s1 <= bus.puf_qn;
            r_qn_s2 <= r_qn_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = PRE;
                end
            end
            PRE:    if (r_cyc_cnt == CYC_W'(PRE_CYC - 1)) w_next_state = EVAL;
            EVAL:   if (r_cyc_cnt == CYC_W'(SETTLE - 1))  w_next_state = SAMPLE;
            SAMPLE: w_next_state = (r_eval_cnt == EVC_W'(NEVAL - 1)) ? DONE : PRE;
            DONE:   if (bus.rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Vote results including the sample being taken this cycle, so the
    // response can be registered on the same edge that enters DONE.
    always_comb begin
        w_final_cnt = r_ones_cnt;
        w_final_inv = r_invalid;
        w_maj       = '0;
        w_unst      = '0;
        for (int i = 0; i < N_PUF; i++) begin
            w_final_cnt[i] = r_ones_cnt[i] + CNT_W'(r_q_s2[i]);
            w_final_inv[i] = r_invalid[i] | (r_q_s2[i] == r_qn_s2[i]);
            w_maj[i]       = w_final_cnt[i] > CNT_W'(NEVAL / 2);
            w_unst[i]      = (w_final_cnt[i] != '0) && (w_final_cnt[i] != CNT_W'(NEVAL));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce           <= 1'b0;
            r_cyc_cnt      <= '0;
            r_eval_cnt     <= '0;
            r_sel          <= '0;
            r_ones_cnt     <= '0;
            r_invalid      <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_bits     <= '0;
            r_rsp_unstable <= '0;
            r_rsp_invalid  <= '0;
        end else begin
            r_ce <= (w_next_state == EVAL);

            if ((r_state == PRE || r_state == EVAL) && w_next_state == r_state)
                r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
            else
                r_cyc_cnt <= '0;

            if (w_accept) begin
                r_sel      <= bus.req_sel;
                r_ones_cnt <= '0;
                r_invalid  <= '0;
                r_eval_cnt <= '0;
            end

            if (r_state == SAMPLE) begin
                r_ones_cnt <= w_final_cnt;
                r_invalid  <= w_final_inv;
                if (w_next_state == DONE) begin
                    r_rsp_valid    <= 1'b1;
                    r_rsp_bits     <= w_maj;
                    r_rsp_unstable <= w_unst;
                    r_rsp_invalid  <= w_final_inv;
                end else begin
                    r_eval_cnt <= r_eval_cnt + EVC_W'(1);
                end
            end

            if (r_state == DONE && bus.rsp_ready)
                r_rsp_valid <= 1'b0;
        end
    end

    assign bus.req_ready    = (r_state == IDLE);
    assign bus.puf_sel      = r_sel;
    assign bus.puf_ce       = r_ce;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_bits     = r_rsp_bits;
    assign bus.rsp_unstable = r_rsp_unstable;
    assign bus.rsp_invalid  = r_rsp_invalid;
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed self-checking bench for puf_eval_ctrl with a per-evaluation PUF model
// (Q/Qn precharged high while ce is low, pattern table while ce is high).
module tb_puf_eval_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [5:0] qPat [5];
    logic [5:0] qnPat [5];
    int   pulseCount, highLen, lowLen, minHigh, maxHigh, minGap, maxGap;
    logic prevCe;
    int   lat;

    puf_eval_ctrl_if #(.N_PUF(6), .SEL_W(32)) bus ();

    puf_eval_ctrl #(
        .N_PUF(6), .SEL_W(32), .NEVAL(5), .PRE_CYC(4), .SETTLE(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Pulse-shape monitor and PUF array model, both updated mid-cycle.
    always @(negedge clk) begin
        if (bus.puf_ce) begin
            if (!prevCe) begin
                if (pulseCount > 0) begin
                    if (lowLen < minGap) minGap = lowLen;
                    if (lowLen > maxGap) maxGap = lowLen;
                end
                pulseCount++;
                highLen = 0;
            end
            highLen++;
        end else begin
            if (prevCe) begin
                if (highLen < minHigh) minHigh = highLen;
                if (highLen > maxHigh) maxHigh = highLen;
                lowLen = 0;
            end
            lowLen++;
        end
        prevCe = bus.puf_ce;
        if (bus.puf_ce && pulseCount >= 1 && pulseCount <= 5) begin
            bus.puf_q  = qPat[pulseCount-1];
            bus.puf_qn = qnPat[pulseCount-1];
        end else begin
            bus.puf_q  = '1;
            bus.puf_qn = '1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic resetMonitor();
        pulseCount = 0;
        minHigh    = 1000;
        maxHigh    = 0;
        minGap     = 1000;
        maxGap     = 0;
    endtask

    task automatic setStable(input logic [5:0] q, input logic [5:0] qn);
        for (int i = 0; i < 5; i++) begin
            qPat[i]  = q;
            qnPat[i] = qn;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] sel);
        @(negedge clk);
        checkOutput("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_sel   = sel;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("puf_sel_after_accept", bus.puf_sel, sel);
    endtask

    task automatic waitResponse(output int cycles);
        cycles = 1;
        while (!bus.rsp_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic finishResponse();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_ready", 32'(bus.rsp_valid), 32'd0);
        checkOutput("req_ready_after_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        prevCe    = 1'b0;
        highLen   = 0;
        lowLen    = 0;
        resetMonitor();
        setStable(6'b101101, 6'b010010);

        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_sel   = 32'hA5A5_5A5A;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_puf_ce",       32'(bus.puf_ce),       32'd0);
        checkOutput("rst_puf_sel",      bus.puf_sel,           32'd0);
        checkOutput("rst_rsp_valid",    32'(bus.rsp_valid),    32'd0);
        checkOutput("rst_rsp_bits",     32'(bus.rsp_bits),     32'd0);
        checkOutput("rst_rsp_unstable", 32'(bus.rsp_unstable), 32'd0);
        checkOutput("rst_rsp_invalid",  32'(bus.rsp_invalid),  32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rel_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rel_puf_sel",   bus.puf_sel,        32'd0);

        // Stable challenge with latency, ce pulse shape and backpressure.
        resetMonitor();
        applyStimulus(32'hDEADBEEF);
        waitResponse(lat);
        checkOutput("stable_latency",  32'(lat),              32'd66);
        checkOutput("stable_bits",     32'(bus.rsp_bits),     32'h2D);
        checkOutput("stable_unstable", 32'(bus.rsp_unstable), 32'h00);
        checkOutput("stable_invalid",  32'(bus.rsp_invalid),  32'h00);
        checkOutput("ce_pulses",       32'(pulseCount),       32'd5);
        checkOutput("ce_high_min",     32'(minHigh),          32'd8);
        checkOutput("ce_high_max",     32'(maxHigh),          32'd8);
        checkOutput("ce_gap_min",      32'(minGap),           32'd5);
        checkOutput("ce_gap_max",      32'(maxGap),           32'd5);

        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                bus.req_valid = 1'b1;
                bus.req_sel   = 32'h1234_5678;
            end
            if (c == 6) bus.req_valid = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("bp_rsp_bits",  32'(bus.rsp_bits),  32'h2D);
        end
        bus.req_valid = 1'b0;
        checkOutput("bp_puf_sel", bus.puf_sel,        32'hDEADBEEF);
        checkOutput("bp_puf_ce",  32'(bus.puf_ce),    32'd0);
        finishResponse();
        checkOutput("bp_sel_hold", bus.puf_sel, 32'hDEADBEEF);

        // Noisy bits 0/1, consumer always ready.
        qPat[0] = 6'b101001; qPat[1] = 6'b101000; qPat[2] = 6'b101011;
        qPat[3] = 6'b101001; qPat[4] = 6'b101000;
        for (int i = 0; i < 5; i++) qnPat[i] = ~qPat[i];
        bus.rsp_ready = 1'b1;
        resetMonitor();
        applyStimulus(32'h0000_00A5);
        waitResponse(lat);
        checkOutput("noisy_latency",  32'(lat),              32'd66);
        checkOutput("noisy_bits",     32'(bus.rsp_bits),     32'h29);
        checkOutput("noisy_unstable", 32'(bus.rsp_unstable), 32'h03);
        checkOutput("noisy_invalid",  32'(bus.rsp_invalid),  32'h00);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput("noisy_drop_valid", 32'(bus.rsp_valid), 32'd0);

        // Bit 5 shows Q==Qn on evaluation 3 only; other samples of bit 5 are 0.
        setStable(6'b001101, 6'b110010);
        qPat[2] = 6'b101101;
        resetMonitor();
        applyStimulus(32'h5555_AAAA);
        waitResponse(lat);
        checkOutput("inv_latency",  32'(lat),              32'd66);
        checkOutput("inv_bits",     32'(bus.rsp_bits),     32'h0D);
        checkOutput("inv_unstable", 32'(bus.rsp_unstable), 32'h20);
        checkOutput("inv_invalid",  32'(bus.rsp_invalid),  32'h20);
        finishResponse();

        // Abort during evaluation 2 with a run that would flag everything.
        setStable(6'b111111, 6'b111111);
        resetMonitor();
        applyStimulus(32'hCAFE_F00D);
        lat = 0;
        while (!(pulseCount == 2 && bus.puf_ce) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("abort_reached_eval2", 32'(lat < 100), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_puf_ce",    32'(bus.puf_ce),    32'd0);
        checkOutput("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("abort_puf_sel",   bus.puf_sel,        32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        setStable(6'b010010, 6'b101101);
        resetMonitor();
        applyStimulus(32'h0F0F_0F0F);
        waitResponse(lat);
        checkOutput("post_latency",  32'(lat),              32'd66);
        checkOutput("post_bits",     32'(bus.rsp_bits),     32'h12);
        checkOutput("post_unstable", 32'(bus.rsp_unstable), 32'h00);
        checkOutput("post_invalid",  32'(bus.rsp_invalid),  32'h00);
        checkOutput("post_pulses",   32'(pulseCount),       32'd5);
        finishResponse();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
- Sequencer that sits directly in front of and behind the 6-cell PUF array.
- Accepts a 32-bit challenge and drives the array's `sel` and `ce`.
- Runs NEVAL precharge/evaluate cycles, samples `Q`/`Qn` through synchronizers, and majority-votes each bit.
- Returns a 6-bit response with per-bit instability and invalid flags over a valid/ready handshake.

Parameters:
- N_PUF, 6: number of PUF cells (width of Q/Qn/response).
- SEL_W, 32: challenge width.
- NEVAL, 5: evaluations per challenge; odd, >=1.
- PRE_CYC, 4: cycles ce held low before each evaluation; >=1.
- SETTLE, 8: cycles ce held high before sampling; >=3 (covers 2-flop sync + 1).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  challenge request.
- req_ready  out  1  controller can accept a request.
- req_sel  in  SEL_W  challenge.
- puf_sel  out  SEL_W  to array sel.
- puf_ce  out  1  to array ce.
- puf_q  in  N_PUF  array Q (asynchronous to clk).
- puf_qn  in  N_PUF  array Qn (asynchronous to clk).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_bits  out  N_PUF  majority-voted response.
- rsp_unstable  out  N_PUF  bit did not vote unanimously.
- rsp_invalid  out  N_PUF  Q==Qn seen at any sample.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; puf_ce=0, puf_sel=0; rsp_valid=0, rsp_bits/unstable/invalid=0.
  - Vote counters, eval counter, and synchronizers cleared.
  - req_ready=1 in the first cycle after release.
- Synchronizers: 2-flop sync on puf_q and puf_qn, always running. Samples use the second stage.
- State machine (all outputs registered; req_ready = state==IDLE):
  - IDLE: on req_valid&req_ready, latch req_sel into puf_sel, clear vote counters, invalid flags, and eval counter, then go to PRE. puf_sel holds until the next accept.
  - PRE: puf_ce=0 for PRE_CYC cycles, then EVAL.
  - EVAL: puf_ce=1 for SETTLE cycles, then SAMPLE.
  - SAMPLE: one cycle, puf_ce=0.
    - Per bit: ones_cnt += q_s; invalid |= (q_s==qn_s).
    - If eval_cnt==NEVAL-1, go to DONE; else increment eval_cnt and go to PRE.
  - DONE: rsp_valid=1. rsp_bits[i] = ones_cnt[i] > NEVAL/2. rsp_unstable[i] = ones_cnt[i]!=0 && ones_cnt[i]!=NEVAL. rsp_invalid = sticky flags.
    - Response outputs are stable while rsp_valid&!rsp_ready.
    - On rsp_ready: go to IDLE and drop rsp_valid next cycle. No same-cycle re-accept.
- Widths: ones_cnt per bit is clog2(NEVAL+1) bits and never overflows. eval_cnt is clog2(NEVAL) bits, minimum 1.
- Latency (request accepted in cycle T): PRE entered at T+1. Each evaluation takes PRE_CYC+SETTLE+1 cycles. rsp_valid rises at T+1+NEVAL*(PRE_CYC+SETTLE+1); 66 cycles with defaults.
- req_valid while not ready: ignored, no buffering.
- Reset mid-operation: puf_ce drops asynchronously, partial votes are discarded, and no response is produced.
- rsp_ready while rsp_valid=0: ignored.
- NEVAL=1: a single sample; rsp_unstable is always 0.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 with arbitrary inputs, then release.
  - Required: all outputs 0; req_ready=1 the cycle after release.
- Stable model (Q=6'b101101, Qn=~Q), accept req_sel=32'hDEADBEEF at T:
  - puf_sel=DEADBEEF from T+1.
  - Five puf_ce pulses, 8 cycles high each, separated by 5 low cycles.
  - rsp_valid at T+66 with rsp_bits=101101, unstable=0, invalid=0.
- Noisy model:
  - Stimulus: bit0 samples 1,0,1,1,0; bit1 samples 0,0,1,0,0.
  - Required: rsp_bits[0]=1, rsp_bits[1]=0; rsp_unstable=6'b000011.
- Invalid model:
  - Stimulus: bit5 drives Q=Qn=1 during evaluation 3 only.
  - Required: rsp_invalid=6'b100000; rsp_bits[5] follows the majority of the remaining samples.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles after rsp_valid; pulse req_valid meanwhile.
  - Required: outputs stable; req_ready=0; request not taken.
  - Then raise rsp_ready: rsp_valid=0 and req_ready=1 on the following cycle.
- Reset mid-EVAL:
  - Stimulus: assert rst_n=0 during evaluation 2.
  - Required: puf_ce=0 immediately; rsp_valid=0.
  - A new request with stable model 6'b010010 returns exactly 010010, unstable=0, with no residue from the aborted run.
